// File: rtl/button_stepper.sv
// Turns a debounced button level into press/step/release pulses with auto-repeat
// and short/long release classification, timed in clk_en ticks.
module button_stepper #(
  parameter int CNT_W         = 12,
  parameter int LONG_MS       = 500,
  parameter int REPEAT_DELAY  = 400,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             in,
  input  logic             repeat_en,
  output logic             press,
  output logic             step,
  output logic             release_pulse,  // "release" is a reserved word
  output logic             release_long,
  output logic             held,
  output logic [CNT_W-1:0] hold_ms
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_REPEAT = 2'd1,
    REPEATING   = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   ONE_X    = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   DELAY_X  = (CNT_W+1)'(REPEAT_DELAY);
  localparam logic [CNT_W:0]   PERIOD_X = (CNT_W+1)'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] LONG_X   = CNT_W'(LONG_MS);

  state_t           state_q, state_d;
  logic             press_q, press_d;
  logic             step_q, step_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  logic [CNT_W:0]   hold_inc;
  logic [CNT_W-1:0] hold_sat;
  logic [CNT_W:0]   rep_inc;

  // One extra bit so a saturated hold_ms can never alias REPEAT_DELAY.
  assign hold_inc = {1'b0, hold_q} + ONE_X;
  assign hold_sat = hold_inc[CNT_W] ? hold_q : hold_inc[CNT_W-1:0];
  assign rep_inc  = {1'b0, rep_q} + ONE_X;

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    step_d    = 1'b0;
    release_d = 1'b0;
    long_d    = long_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    case (state_q)
      IDLE: begin
        if (in) begin
          state_d = WAIT_REPEAT;
          hold_d  = '0;
          press_d = 1'b1;
          step_d  = 1'b1;
        end
      end
      WAIT_REPEAT: begin
        if (!in) begin
          state_d   = IDLE;
          release_d = 1'b1;
          long_d    = (hold_q >= LONG_X);
        end else if (clk_en) begin
          hold_d = hold_sat;
          if ((hold_inc == DELAY_X) && repeat_en) begin
            state_d = REPEATING;
            step_d  = 1'b1;
            rep_d   = '0;
          end
        end
      end
      REPEATING: begin
        if (!in) begin
          state_d   = IDLE;
          release_d = 1'b1;
          long_d    = (hold_q >= LONG_X);
        end else if (clk_en) begin
          hold_d = hold_sat;
          if (rep_inc == PERIOD_X) begin
            rep_d  = '0;
            step_d = repeat_en;
          end else begin
            rep_d = rep_inc[CNT_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      press_q   <= 1'b0;
      step_q    <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      hold_q    <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      step_q    <= step_d;
      release_q <= release_d;
      long_q    <= long_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
    end
  end

  assign press         = press_q;
  assign step          = step_q;
  assign release_pulse = release_q;
  assign release_long  = long_q;
  assign held          = (state_q != IDLE);
  assign hold_ms       = hold_q;

endmodule

// File: tb/tb_button_stepper.sv
// Directed bench for button_stepper: default-parameter instance plus a narrow
// CNT_W=4 instance for saturation.
module tb_button_stepper;

  logic clk = 1'b0;
  logic reset, clk_en, in, repeat_en;

  logic        press, step, release_pulse, release_long, held;
  logic [11:0] hold_ms;
  logic        press2, step2, release2, long2, held2;
  logic [3:0]  hold2;

  int unsigned press_cnt = 0, step_cnt = 0, rel_cnt = 0;
  int unsigned p0, s0, r0;
  int vectors = 0;
  int errs    = 0;
  logic held_bad;

  always #5 clk = ~clk;

  button_stepper dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in(in), .repeat_en(repeat_en),
    .press(press), .step(step), .release_pulse(release_pulse),
    .release_long(release_long), .held(held), .hold_ms(hold_ms)
  );

  button_stepper #(.CNT_W(4), .LONG_MS(10), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in(in), .repeat_en(repeat_en),
    .press(press2), .step(step2), .release_pulse(release2),
    .release_long(long2), .held(held2), .hold_ms(hold2)
  );

  always @(negedge clk) begin
    press_cnt <= press_cnt + 32'(press);
    step_cnt  <= step_cnt + 32'(step);
    rel_cnt   <= rel_cnt + 32'(release_pulse);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_press();
    in = 1'b1;
    @(negedge clk);
  endtask

  task automatic snap();
    p0 = press_cnt;
    s0 = step_cnt;
    r0 = rel_cnt;
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; clk_en = 1'b0; repeat_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pulses", {28'd0, press, step, release_pulse, release_long}, 32'd0);
    chk("reset_held", {31'd0, held}, 32'd0);
    chk("reset_hold_ms", {20'd0, hold_ms}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // one-cycle glitch
    snap();
    do_press();
    chk("glitch_press", {30'd0, press, step}, 32'd3);
    chk("glitch_held", {31'd0, held}, 32'd1);
    in = 1'b0;
    @(negedge clk);
    chk("glitch_release", {29'd0, release_pulse, press, release_long}, 32'd4);
    chk("glitch_hold_ms", {20'd0, hold_ms}, 32'd0);
    @(negedge clk);

    // short press, 50 ticks
    snap();
    held_bad = 1'b0;
    do_press();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!held) held_bad = 1'b1;
    end
    in = 1'b0;
    @(negedge clk);
    chk("short_release", {30'd0, release_pulse, release_long}, 32'd2);
    chk("short_hold_ms", {20'd0, hold_ms}, 32'd50);
    @(negedge clk);
    chk("short_press_cnt", press_cnt - p0, 32'd1);
    chk("short_step_cnt", step_cnt - s0, 32'd1);
    chk("short_rel_cnt", rel_cnt - r0, 32'd1);
    chk("short_held_thru", {31'd0, held_bad}, 32'd0);

    // long hold 650 ticks with auto-repeat
    snap();
    do_press();
    repeat (400) tick();
    chk("long_hold_400", {20'd0, hold_ms}, 32'd400);
    chk("long_steps_400", step_cnt - s0, 32'd2);
    repeat (250) tick();
    in = 1'b0;
    @(negedge clk);
    chk("long_release", {30'd0, release_pulse, release_long}, 32'd3);
    chk("long_hold_ms", {20'd0, hold_ms}, 32'd650);
    chk("long_step_cnt", step_cnt - s0, 32'd4);
    @(negedge clk);

    // same hold with auto-repeat disabled
    repeat_en = 1'b0;
    snap();
    do_press();
    repeat (650) tick();
    in = 1'b0;
    @(negedge clk);
    chk("norep_release", {30'd0, release_pulse, release_long}, 32'd3);
    chk("norep_hold_ms", {20'd0, hold_ms}, 32'd650);
    chk("norep_step_cnt", step_cnt - s0, 32'd1);
    @(negedge clk);
    repeat_en = 1'b1;

    // release coincident with the tick that would start repeating
    snap();
    do_press();
    repeat (399) tick();
    chk("edge_hold_399", {20'd0, hold_ms}, 32'd399);
    in = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    chk("edge_release", {29'd0, release_pulse, step, release_long}, 32'd4);
    chk("edge_hold_kept", {20'd0, hold_ms}, 32'd399);
    chk("edge_step_cnt", step_cnt - s0, 32'd1);
    in = 1'b1;
    @(negedge clk);
    chk("repress_press", {31'd0, press}, 32'd1);
    chk("repress_hold_ms", {20'd0, hold_ms}, 32'd0);
    in = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // saturation on the narrow instance
    do_press();
    repeat (20) tick();
    in = 1'b0;
    @(negedge clk);
    chk("sat_release", {30'd0, release2, long2}, 32'd3);
    chk("sat_hold_ms", {28'd0, hold2}, 32'd15);
    chk("wide_hold_20", {20'd0, hold_ms}, 32'd20);
    chk("wide_long_20", {31'd0, release_long}, 32'd0);
    @(negedge clk);

    // asynchronous reset while repeating
    do_press();
    repeat (450) tick();
    chk("pre_reset_hold", {20'd0, hold_ms}, 32'd450);
    chk("pre_reset_held", {31'd0, held}, 32'd1);
    snap();
    reset = 1'b1;
    #1;
    chk("async_reset_outs", {27'd0, press, step, release_pulse, held, release_long}, 32'd0);
    chk("async_reset_hold", {20'd0, hold_ms}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_press", {30'd0, press, step}, 32'd3);
    chk("post_reset_hold", {20'd0, hold_ms}, 32'd0);
    chk("reset_no_release", rel_cnt - r0, 32'd0);
    in = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
